// File: rtl/mask_morph3x3.sv
// Streaming 3x3 erode (or, with MASK_DILATE_EN, erode/dilate) on a 1-bit mask.
// Syncs and pixels leave aligned with the filtered mask, H_TOTAL+2 clocks later.
module mask_morph3x3 #(
   parameter int IMG_W   = 64,
   parameter int IMG_H   = 64,
   parameter int H_TOTAL = 80
) (
   input  logic        clk,
   input  logic        rst_n,
`ifdef MASK_DILATE_EN
   input  logic        mode,
`endif
   input  logic        de,
   input  logic        hsync,
   input  logic        vsync,
   input  logic        mask_in,
   input  logic [23:0] pixel_in,
   output logic        de_out,
   output logic        hsync_out,
   output logic        vsync_out,
   output logic        mask_out,
   output logic [23:0] pixel_out
);

   localparam int FILL = H_TOTAL + 2;
   localparam int CW   = $clog2(FILL + 1);
   localparam int PW   = $clog2(H_TOTAL);
   localparam int DW   = 27;
   // An active line that does not fit in the total line can never be filtered
   localparam bit GEOM_OK = (IMG_W < H_TOTAL) && (IMG_H > 0);

   logic [CW-1:0] cnt_q, cnt_d;
   logic [PW-1:0] ptr_q, ptr_d;
   logic [2:0]    col1_q, col1_d;
   logic [2:0]    col2_q, col2_d;
   logic          mask_q, mask_d;

   logic          lb1_q [H_TOTAL];
   logic          lb2_q [H_TOTAL];
   logic [DW-1:0] dly_q [FILL];

   logic          filled;
   logic          lb_ok;
   logic          v;
   logic          tap1;
   logic          tap2;
   logic [2:0]    col0;
   logic [8:0]    win;
   logic          win_and;
   logic          m;
`ifdef MASK_DILATE_EN
   logic          win_or;
`endif

   always_comb begin
      filled = (cnt_q == CW'(FILL));
      // Line slots not yet rewritten since reset read as zero padding
      lb_ok  = GEOM_OK && (cnt_q >= CW'(H_TOTAL));
      v      = mask_in & de;
      tap1   = lb1_q[ptr_q] & lb_ok;
      tap2   = lb2_q[ptr_q] & lb_ok;
      col0   = {tap2, tap1, v};
      win    = {col0, col1_q, col2_q};
   end

   always_comb begin
      cnt_d  = filled ? cnt_q : cnt_q + 1'b1;
      ptr_d  = (ptr_q == PW'(H_TOTAL - 1)) ? '0 : ptr_q + 1'b1;
      col1_d = col0;
      col2_d = col1_q;
   end

   always_comb begin
      win_and = &win;
`ifdef MASK_DILATE_EN
      win_or  = |win;
      m       = mode ? win_or : win_and;
`else
      m       = win_and;
`endif
      mask_d  = m & dly_q[FILL-2][DW-1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         ptr_q  <= '0;
         col1_q <= '0;
         col2_q <= '0;
         mask_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         ptr_q  <= ptr_d;
         col1_q <= col1_d;
         col2_q <= col2_d;
         mask_q <= mask_d;
      end
   end

   // Storage only; fill-counter gating hides stale contents after reset
   always_ff @(posedge clk) begin
      lb1_q[ptr_q] <= v;
      lb2_q[ptr_q] <= tap1;
      dly_q[0]     <= {de, hsync, vsync, pixel_in};
      for (int i = 1; i < FILL; i++) begin
         dly_q[i] <= dly_q[i-1];
      end
   end

   always_comb begin
      de_out    = dly_q[FILL-1][26] & filled;
      hsync_out = dly_q[FILL-1][25] & filled;
      vsync_out = dly_q[FILL-1][24] & filled;
      pixel_out = dly_q[FILL-1][23:0] & {24{filled}};
      mask_out  = mask_q & filled;
   end

endmodule
